// File: rtl/tmr_voter_scrub.sv
`default_nettype none
// ============================================================================
// Module   : tmr_voter_scrub
// Brief    : Registered bitwise-majority voter over three replica buses with
//            per-replica fault tracking, resync handshake and error statistics.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module tmr_voter_scrub #(
    parameter int WIDTH  = 8,
    parameter int THRESH = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic             clr_stats,
    input  logic [2:0]       resync_ack,
    output logic [WIDTH-1:0] voted,
    output logic             voted_valid,
    output logic [2:0]       mismatch,
    output logic [2:0]       resync_req,
    output logic [2:0]       replica_ok,
    output logic             degraded,
    output logic             sticky_err,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt2
);

    localparam logic [CNT_W-1:0] c_THRESH  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_RESYNC  = 2'd2
    } state_t;

    logic [WIDTH-1:0] w_maj;
    logic [2:0]       w_diff;
    logic [2:0]       w_resync_n;

    assign w_maj  = (r0 & r1) | (r0 & r2) | (r1 & r2);
    assign w_diff = {r2 != w_maj, r1 != w_maj, r0 != w_maj};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_replica
            state_t           r_state, w_state_n;
            logic [CNT_W-1:0] r_con, w_con_n, w_con_inc;
            logic [CNT_W-1:0] r_err_cnt;

            assign w_con_inc = (r_con < c_THRESH) ? r_con + c_ONE : r_con;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= ST_OK;
                    r_con   <= '0;
                end else begin
                    r_state <= w_state_n;
                    r_con   <= w_con_n;
                end
            end

            // Only the ack leaves RESYNC; disagreements there do not touch con.
            always_comb begin
                w_state_n = r_state;
                w_con_n   = r_con;
                case (r_state)
                    ST_OK: begin
                        if (in_valid && w_diff[gi]) begin
                            w_con_n   = c_ONE;
                            w_state_n = (c_THRESH == c_ONE) ? ST_RESYNC : ST_SUSPECT;
                        end else if (in_valid) begin
                            w_con_n = '0;
                        end
                    end
                    ST_SUSPECT: begin
                        if (in_valid && w_diff[gi]) begin
                            w_con_n = w_con_inc;
                            if (w_con_inc >= c_THRESH) w_state_n = ST_RESYNC;
                        end else if (in_valid) begin
                            w_con_n   = '0;
                            w_state_n = ST_OK;
                        end
                    end
                    ST_RESYNC: begin
                        if (resync_ack[gi] && resync_req[gi]) begin
                            w_con_n   = '0;
                            w_state_n = ST_OK;
                        end
                    end
                    default: begin
                        w_con_n   = '0;
                        w_state_n = ST_OK;
                    end
                endcase
            end

            assign w_resync_n[gi] = (w_state_n == ST_RESYNC);

            always_ff @(posedge clk) begin
                if (rst || clr_stats) begin
                    r_err_cnt <= '0;
                end else if (in_valid && w_diff[gi] && (r_err_cnt != c_CNT_MAX)) begin
                    r_err_cnt <= r_err_cnt + c_ONE;
                end
            end
        end
    endgenerate

    assign err_cnt0 = g_replica[0].r_err_cnt;
    assign err_cnt1 = g_replica[1].r_err_cnt;
    assign err_cnt2 = g_replica[2].r_err_cnt;

    // Status outputs follow the next state so they line up with the FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            voted       <= '0;
            voted_valid <= 1'b0;
            mismatch    <= '0;
            resync_req  <= '0;
            replica_ok  <= 3'b111;
            degraded    <= 1'b0;
        end else begin
            voted_valid <= in_valid;
            if (in_valid) begin
                voted    <= w_maj;
                mismatch <= w_diff;
            end
            resync_req <= w_resync_n;
            replica_ok <= ~w_resync_n;
            degraded   <= (w_resync_n[0] & w_resync_n[1]) |
                          (w_resync_n[0] & w_resync_n[2]) |
                          (w_resync_n[1] & w_resync_n[2]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            sticky_err <= 1'b0;
        end else if (in_valid && (|w_diff)) begin
            sticky_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/tmr_voter_scrub.md
Name: tmr_voter_scrub

Overview:
Parametrised successor to the 8-bit triple-replica majority voter.
- Registers a bitwise-majority output of WIDTH bits from three replica buses.
- Tracks per-replica disagreement with consecutive and total counters.
- Drives a per-replica resync handshake once a replica is judged faulty.
- Flags loss of voting integrity when two or more replicas are out of service.
- Sits between the replicated cores and downstream logic in the fault-injection demo.

Parameters:
WIDTH, 8, data width of each replica bus and of the voted output
THRESH, 3, consecutive mismatching valid samples that declare a replica faulty (1..2^CNT_W-1)
CNT_W, 8, width of each per-replica error counter (saturating)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  r0/r1/r2 hold a sample this cycle
r0  in  WIDTH  replica 0 data
r1  in  WIDTH  replica 1 data
r2  in  WIDTH  replica 2 data
clr_stats  in  1  clears err_cnt and sticky_err
resync_ack  in  3  bit i: replica i has been reloaded from the voted state
voted  out  WIDTH  registered bitwise majority
voted_valid  out  1  voted is valid this cycle
mismatch  out  3  registered: bit i set when ri differed from the majority on the last valid sample
resync_req  out  3  bit i: replica i requests a reload
replica_ok  out  3  bit i: replica i is in OK or SUSPECT
degraded  out  1  two or more replicas are in RESYNC
sticky_err  out  1  any mismatch seen since reset or clr_stats
err_cnt0  out  CNT_W  total mismatching samples, replica 0
err_cnt1  out  CNT_W  total mismatching samples, replica 1
err_cnt2  out  CNT_W  total mismatching samples, replica 2

Behaviour:
- All state updates on posedge clk. rst is synchronous and has priority over every other input.
- Reset values: voted=0, voted_valid=0, mismatch=0, resync_req=0, replica_ok=3'b111, degraded=0, sticky_err=0, err_cnt*=0, all FSMs in OK, all consecutive counters 0.
- Voting:
  - m = bitwise majority(r0,r1,r2).
  - On in_valid: voted<=m, voted_valid<=1. Latency is 1 cycle.
  - On !in_valid: voted holds and voted_valid<=0.
  - All three replicas vote at all times, including replicas in RESYNC.
- Per-replica miscompare: d_i = (ri != m). It is evaluated only when in_valid=1. Registered mismatch[i] <= d_i on valid cycles and holds otherwise.
- Counters:
  - err_cnt_i increments on every valid cycle with d_i=1 and saturates at 2^CNT_W-1.
  - The internal consecutive counter con_i increments on d_i=1 and resets to 0 on a valid sample with d_i=0. It saturates at THRESH.
- Per-replica FSM, states OK, SUSPECT, RESYNC:
  - OK -> SUSPECT when a valid sample has d_i=1. con_i becomes 1. If THRESH=1, go directly to RESYNC.
  - SUSPECT -> OK when a valid sample has d_i=0.
  - SUSPECT -> RESYNC when con_i reaches THRESH on that sample.
  - RESYNC holds resync_req[i]=1, registered and asserted in the cycle after entry.
  - RESYNC -> OK on the first cycle resync_ack[i]=1 while resync_req[i]=1. That cycle: con_i<=0, and resync_req[i] drops the next cycle.
  - In RESYNC, d_i still updates err_cnt_i and mismatch[i], but not con_i.
  - resync_ack[i] is ignored in OK and SUSPECT.
- replica_ok[i] = state_i != RESYNC, registered.
- degraded: registered, set when two or more replicas are in RESYNC.
- sticky_err is set on any valid d_i=1.
- clr_stats=1 zeros err_cnt* and sticky_err. If a mismatch arrives in the same cycle, clr_stats wins; that sample is not counted. FSMs, con_i and mismatch are unaffected by clr_stats.
- Simultaneous events:
  - A mismatch in the same cycle as resync_ack: the ack wins, and the state returns to OK with con_i=0.
  - A triple disagreement (all pairs differ) still produces a bitwise majority. Each replica's d_i is evaluated independently.
- Reset during RESYNC drops resync_req in the cycle following rst assertion.

Test Plan:
- Reset, then valid r0=r1=r2=8'hA5 for 4 cycles -> voted=8'hA5 one cycle after each sample, voted_valid=1, mismatch=0, err_cnt*=0, replica_ok=3'b111.
- r1=8'h5A with r0=r2=8'h3C for 1 valid cycle, then all equal -> voted=8'h3C, mismatch=3'b010, err_cnt1=1, sticky_err=1, replica 1 goes OK->SUSPECT->OK, no resync_req.
- r2 corrupted for 3 consecutive valid cycles (THRESH=3) -> resync_req=3'b100 one cycle after the third sample, replica_ok=3'b011. Pulse resync_ack[2] -> req drops next cycle, replica_ok=3'b111.
- r0 and r1 each corrupted 3 cycles with no ack -> degraded=1. Ack replica 0 only -> degraded=0.
- 300 consecutive mismatches on r0 (CNT_W=8) -> err_cnt0 saturates at 255. clr_stats concurrent with a mismatch -> err_cnt0=0, sticky_err=0.
- Assert rst while resync_req=3'b001 -> all outputs at reset values the next cycle. A mismatch in the same cycle as resync_ack -> state OK, con reset.
